// File: rtl/key_tone_player.sv
// Key-press tone player: queues keypad press edges in a small FIFO and plays each as a
// fixed-length square-wave note followed by silence. Define KEY_TONE_LED_EN to add led[3:0].
module key_tone_player #(
    parameter int HALF_P0     = 95556,
    parameter int HALF_P1     = 75843,
    parameter int HALF_P4     = 63776,
    parameter int HALF_P7     = 47778,
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_0,
    input  logic                     push_1,
    input  logic                     push_4,
    input  logic                     push_7,
    output logic                     spk,
    output logic                     busy,
    output logic [1:0]               note_idx,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef KEY_TONE_LED_EN
    ,
    output logic [3:0]               led
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t         state_q, state_d;
    logic [3:0]     push_prev_q, push_prev_d;
    logic [1:0]     mem_q [DEPTH];
    logic [1:0]     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [1:0]     note_q, note_d;
    logic [23:0]    half_q, half_d, div_q, div_d, dur_q, dur_d;
    logic           spk_q, spk_d;

    logic [3:0]     keys, ev;
    logic           ev_any, pop, full, push_ok;
    logic [1:0]     ev_idx;

    // Press events and FIFO bookkeeping
    always_comb begin
        keys        = {push_7, push_4, push_1, push_0};
        push_prev_d = keys;
        ev          = keys & ~push_prev_q;
        ev_any      = |ev;
        ev_idx      = 2'd3;
        if (ev[0])      ev_idx = 2'd0;
        else if (ev[1]) ev_idx = 2'd1;
        else if (ev[2]) ev_idx = 2'd2;

        // A LOAD pop frees a slot in the same cycle, so a full FIFO can still accept.
        pop     = (state_q == LOAD);
        full    = (count_q == CW'(DEPTH));
        push_ok = ev_any && (!full || pop);

        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = ev_idx;
        wr_ptr_d   = wr_ptr_q + (push_ok ? AW'(1) : AW'(0));
        rd_ptr_d   = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = overflow_q | (ev_any & full & ~pop);
    end

    // Note sequencer
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        half_d  = half_q;
        div_d   = div_q;
        dur_d   = dur_q;
        spk_d   = spk_q;
        case (state_q)
            IDLE: begin
                spk_d = 1'b0;
                if (count_q != '0) begin
                    state_d = LOAD;
                    note_d  = mem_q[rd_ptr_q];
                end
            end
            LOAD: begin
                case (note_q)
                    2'd0:    half_d = 24'(HALF_P0);
                    2'd1:    half_d = 24'(HALF_P1);
                    2'd2:    half_d = 24'(HALF_P4);
                    default: half_d = 24'(HALF_P7);
                endcase
                div_d   = '0;
                dur_d   = '0;
                spk_d   = 1'b0;
                state_d = PLAY;
            end
            PLAY: begin
                dur_d = dur_q + 24'd1;
                if (div_q == half_q - 24'd1) begin
                    spk_d = ~spk_q;
                    div_d = '0;
                end else begin
                    div_d = div_q + 24'd1;
                end
                if (dur_q == 24'(NOTE_CYCLES - 1)) begin
                    state_d = GAP;
                    spk_d   = 1'b0;
                    div_d   = '0;
                    dur_d   = '0;
                end
            end
            default: begin
                spk_d = 1'b0;
                dur_d = dur_q + 24'd1;
                if (dur_q == 24'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    dur_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            push_prev_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            note_q      <= '0;
            half_q      <= '0;
            div_q       <= '0;
            dur_q       <= '0;
            spk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            push_prev_q <= push_prev_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            note_q      <= note_d;
            half_q      <= half_d;
            div_q       <= div_d;
            dur_q       <= dur_d;
            spk_q       <= spk_d;
        end
    end

    assign spk        = spk_q;
    assign busy       = (state_q != IDLE);
    assign note_idx   = note_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

`ifdef KEY_TONE_LED_EN
    assign led = (state_q == LOAD || state_q == PLAY) ? (4'b0001 << note_q) : 4'b0000;
`endif

endmodule

// File: tb/tb_key_tone_player.sv
// Directed bench for key_tone_player with tiny note/gap lengths; led checks are
// compiled in when KEY_TONE_LED_EN is defined.
module tb_key_tone_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       push_0, push_1, push_4, push_7;
    logic       spk, busy, overflow;
    logic [1:0] note_idx;
    logic [2:0] fifo_count;
`ifdef KEY_TONE_LED_EN
    logic [3:0] led;
`endif

    int errors = 0;
    int checks = 0;

    key_tone_player #(
        .HALF_P0(2), .HALF_P1(3), .HALF_P4(4), .HALF_P7(5),
        .NOTE_CYCLES(20), .GAP_CYCLES(4), .DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .push_0(push_0), .push_1(push_1), .push_4(push_4), .push_7(push_7),
        .spk(spk), .busy(busy), .note_idx(note_idx),
        .fifo_count(fifo_count), .overflow(overflow)
`ifdef KEY_TONE_LED_EN
        , .led(led)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input int k);
        push_0 = (k == 0);
        push_1 = (k == 1);
        push_4 = (k == 2);
        push_7 = (k == 3);
    endtask

    task automatic check_led(input string tag, input logic [3:0] exp);
`ifdef KEY_TONE_LED_EN
        check(tag, led, exp);
`endif
    endtask

    // Waits (bounded) for the LOAD cycle, then checks the whole note and its gap.
    task automatic play_note(input int idx, input int half, input string tag);
        int n = 0;
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        @(negedge clk);
        while (!busy && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({tag, " load busy"}, busy, 1);
        check({tag, " load note"}, note_idx, idx);
        check({tag, " load spk"}, spk, 0);
        check_led({tag, " load led"}, oh);
        for (int p = 0; p < 20; p++) begin
            @(negedge clk);
            check($sformatf("%s play%0d spk", tag, p), spk, (p / half) % 2);
            check($sformatf("%s play%0d busy", tag, p), busy, 1);
            check_led($sformatf("%s play%0d led", tag, p), oh);
        end
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            check($sformatf("%s gap%0d spk", tag, g), spk, 0);
            check($sformatf("%s gap%0d busy", tag, g), busy, 1);
            check_led($sformatf("%s gap%0d led", tag, g), 4'b0000);
        end
        @(negedge clk);
        check({tag, " idle busy"}, busy, 0);
        check_led({tag, " idle led"}, 4'b0000);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while ((busy || fifo_count != 0) && n < limit) begin
            n++;
            @(negedge clk);
        end
        check({tag, " reached idle"}, {busy, fifo_count}, 0);
    endtask

    initial begin
        int keys3 [6] = '{0, 1, 2, 3, 0, 1};
        int cnt3  [6] = '{1, 1, 2, 3, 4, 4};
        int ovf3  [6] = '{0, 0, 0, 0, 0, 1};
        int keys5 [5] = '{0, 1, 2, 1, 2};
        int cnt5  [5] = '{1, 1, 2, 3, 4};
        int n;

        reset = 1'b1;
        set_key(-1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst spk", spk, 0);
        check("rst busy", busy, 0);
        check("rst note", note_idx, 0);
        check("rst count", fifo_count, 0);
        check("rst ovf", overflow, 0);
        check_led("rst led", 4'b0000);
        repeat (2) @(negedge clk);

        // 1: held key gives exactly one note
        push_1 = 1'b1;
        @(negedge clk);
        check("t1 count", fifo_count, 1);
        check("t1 busy pre", busy, 0);
        play_note(1, 3, "t1");
        repeat (23) @(negedge clk);
        check("t1 busy end", busy, 0);
        check("t1 count end", fifo_count, 0);
        check("t1 ovf", overflow, 0);
        push_1 = 1'b0;
        repeat (2) @(negedge clk);

        // 2: simultaneous presses, key 0 wins
        push_0 = 1'b1;
        push_7 = 1'b1;
        @(negedge clk);
        check("t2 count", fifo_count, 1);
        set_key(-1);
        play_note(0, 2, "t2");
        check("t2 count end", fifo_count, 0);
        check("t2 ovf", overflow, 0);
        repeat (2) @(negedge clk);

        // 3: six presses, FIFO fills, sixth dropped
        for (int i = 0; i < 6; i++) begin
            set_key(keys3[i]);
            @(negedge clk);
            set_key(-1);
            @(negedge clk);
            check($sformatf("t3 count%0d", i), fifo_count, cnt3[i]);
            check($sformatf("t3 ovf%0d", i), overflow, ovf3[i]);
        end
        n = 0;
        while (busy && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("t3 first note done", busy, 0);
        play_note(1, 3, "t3a");
        play_note(2, 4, "t3b");
        play_note(3, 5, "t3c");
        play_note(0, 2, "t3d");
        check("t3 count end", fifo_count, 0);
        check("t3 ovf sticky", overflow, 1);
        repeat (2) @(negedge clk);

        // 4: reset mid-note discards queue and clears overflow
        push_4 = 1'b1;
        @(negedge clk);
        push_4 = 1'b0;
        check("t4 count", fifo_count, 1);
        @(negedge clk);
        check("t4 load busy", busy, 1);
        check("t4 load note", note_idx, 2);
        repeat (6) @(negedge clk);
        push_0 = 1'b1;
        @(negedge clk);
        push_0 = 1'b0;
        repeat (4) @(negedge clk);
        check("t4 queued", fifo_count, 1);
        check("t4 busy pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4 spk", spk, 0);
        check("t4 busy", busy, 0);
        check("t4 count", fifo_count, 0);
        check("t4 ovf", overflow, 0);
        repeat (3) @(negedge clk);
        check("t4 stays idle", busy, 0);
        push_7 = 1'b1;
        @(negedge clk);
        push_7 = 1'b0;
        check("t4 k7 count", fifo_count, 1);
        play_note(3, 5, "t4");
        repeat (2) @(negedge clk);

        // 5: push accepted on a full FIFO when LOAD pops in the same cycle
        for (int i = 0; i < 5; i++) begin
            set_key(keys5[i]);
            @(negedge clk);
            set_key(-1);
            @(negedge clk);
            check($sformatf("t5 count%0d", i), fifo_count, cnt5[i]);
        end
        check("t5 ovf full", overflow, 0);
        n = 0;
        while (busy && n < 60) begin
            n++;
            @(negedge clk);
        end
        check("t5 idle", busy, 0);
        @(negedge clk);
        check("t5 load busy", busy, 1);
        check("t5 load count", fifo_count, 4);
        push_7 = 1'b1;
        @(negedge clk);
        push_7 = 1'b0;
        check("t5 count kept", fifo_count, 4);
        check("t5 ovf", overflow, 0);
        check("t5 note", note_idx, 1);
        wait_idle(400, "t5");
        check("t5 last note", note_idx, 3);
        check("t5 ovf end", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
